// File: rtl/fdiv_sched.sv
// Issue/retire scheduler for the pipelined fdiv datapath: aligns x1 with the finv latency,
// tags ops, buffers quotients in an in-order FIFO and uses credits so no result is dropped.
module fdiv_sched #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_x1,
  output logic [31:0]      div_x2,
  input  logic [31:0]      div_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             v;
    logic [31:0]      x1;
    logic [TAG_W-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } res_t;

  stage_t           pipe_q [LAT];
  stage_t           pipe_d [LAT];
  res_t             mem_q  [DEPTH];
  res_t             mem_d  [DEPTH];
  res_t             head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             issue, pop, wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: never accept more ops than the FIFO can eventually hold
  assign in_ready  = !flush && (cnt_q < CNT_W'(DEPTH));
  assign issue     = in_valid && in_ready;
  assign pop       = out_valid_q && out_ready && !flush;
  assign wr        = pipe_q[LAT-1].v && !flush;

  assign div_x2    = in_x2;
  assign div_x1    = pipe_q[LAT-1].x1;
  assign out_valid = out_valid_q;
  assign out_data  = head_q.data;
  assign out_tag   = head_q.tag;
  assign busy      = busy_q;

  // Free-running delay line; flush only kills the valid bits
  always_comb begin
    pipe_d[0].v   = issue;
    pipe_d[0].x1  = in_x1;
    pipe_d[0].tag = in_tag;
    for (int unsigned i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (flush) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_d[i].v = 1'b0;
      end
    end
  end

  // Result FIFO with a registered head that bypasses a same-cycle write into an empty FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr) begin
      mem_d[wr_ptr_q].data = div_y;
      mem_d[wr_ptr_q].tag  = pipe_q[LAT-1].tag;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    fill_d = fill_q + CNT_W'(wr) - CNT_W'(pop);
    cnt_d  = cnt_q + CNT_W'(issue) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
    end
    out_valid_d = (fill_d != '0);
    busy_d      = (cnt_d != '0);
    head_d      = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed bench for fdiv_sched; a table-driven fdiv stand-in answers on div_y LAT cycles
// after the divisor is presented, using the scheduler's delayed div_x1.
module tb_fdiv_sched;

  localparam int unsigned TAG_W = 5;

  localparam logic [31:0] T_X1 [8] = '{32'h41000000, 32'h41100000, 32'h3F800000, 32'hC0C00000,
                                       32'h41200000, 32'h41400000, 32'h40000000, 32'h40C00000};
  localparam logic [31:0] T_X2 [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000,
                                       32'h40000000, 32'h40800000, 32'h40000000, 32'h40000000};
  // 8/2, 9/3, 1/4, -6/2, 10/2, 12/4, 2/2, 6/2
  localparam logic [31:0] T_Q  [8] = '{32'h40800000, 32'h40400000, 32'h3E800000, 32'hC0400000,
                                       32'h40A00000, 32'h40400000, 32'h3F800000, 32'h40400000};

  logic             clk, rstn, flush;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]      in_x1, in_x2, div_x1, div_x2, div_y, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0]      x2_d1, x2_d2;
  int               n_chk, n_fail;

  fdiv_sched #(.LAT(2), .DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .div_x1(div_x1), .div_x2(div_x2), .div_y(div_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'hBAD0BAD0;
    for (int i = 0; i < 8; i++) begin
      if (T_X1[i] == a && T_X2[i] == b) r = T_Q[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    x2_d1 <= div_x2;
    x2_d2 <= x2_d1;
  end
  always_comb div_y = fdiv_ref(div_x1, x2_d2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_x1    = T_X1[idx];
    in_x2    = T_X2[idx];
    in_tag   = tag;
  endtask

  initial begin
    int  nxt;
    int  head;
    logic exp_ov, exp_rdy;
    n_chk = 0; n_fail = 0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x1 = '0; in_x2 = '0; in_tag = '0;

    // reset state
    #2;
    chk("rst_ov",   32'(out_valid), 32'd0);
    chk("rst_data", out_data,       32'd0);
    chk("rst_tag",  32'(out_tag),   32'd0);
    chk("rst_dx1",  div_x1,         32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd1);
    tick();
    rstn = 1'b1;
    tick();

    // single op: 6/2 tag 3, latency LAT+1
    tick(); out_ready = 1'b1; drive(1'b1, 7, 5'd3); #1;
    chk("t1_rdy", 32'(in_ready),  32'd1);
    chk("t1_dx2", div_x2,         32'h40000000);
    chk("t1_ov0", 32'(out_valid), 32'd0);
    tick(); in_valid = 1'b0; #1;
    chk("t1_ov1", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("t1_ov2", 32'(out_valid), 32'd0);
    chk("t1_dx1", div_x1,         32'h40C00000);
    tick(); #1;
    chk("t1_ov3",   32'(out_valid), 32'd1);
    chk("t1_data",  out_data,       32'h40400000);
    chk("t1_tag",   32'(out_tag),   32'd3);
    chk("t1_busy1", 32'(busy),      32'd1);
    tick(); #1;
    chk("t1_ov4",   32'(out_valid), 32'd0);
    chk("t1_busy0", 32'(busy),      32'd0);

    // four back-to-back ops, tags 1..4
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 4) drive(1'b1, c, 5'(c + 1));
      else in_valid = 1'b0;
      #1;
      if (c < 4) chk("t2_rdy", 32'(in_ready), 32'd1);
      if (c >= 3 && c <= 6) begin
        chk("t2_ov",   32'(out_valid), 32'd1);
        chk("t2_data", out_data,       T_Q[c-3]);
        chk("t2_tag",  32'(out_tag),   32'(c - 2));
      end else begin
        chk("t2_ov", 32'(out_valid), 32'd0);
      end
    end

    // backpressure: fill with out_ready=0, then drain while the source keeps pushing
    nxt = 0;
    for (int c = 0; c < 17; c++) begin
      tick();
      out_ready = (c >= 8);
      if (nxt < 8) drive(1'b1, nxt, 5'(10 + nxt));
      else in_valid = 1'b0;
      #1;
      exp_rdy = !(c >= 4 && c <= 8);
      chk("t3_rdy", 32'(in_ready), 32'(exp_rdy));
      if (in_valid && in_ready) nxt++;
      exp_ov = (c >= 3 && c <= 15);
      chk("t3_ov", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        head = (c < 8) ? 0 : c - 8;
        chk("t3_tag",  32'(out_tag), 32'(10 + head));
        chk("t3_data", out_data,     T_Q[head]);
      end
    end
    chk("t3_busy", 32'(busy), 32'd0);

    // flush with one buffered result and two ops in flight, then a fresh op
    for (int c = 0; c < 14; c++) begin
      tick();
      flush     = (c == 4);
      out_ready = (c >= 4);
      case (c)
        0:       drive(1'b1, 0, 5'd21);
        2:       drive(1'b1, 1, 5'd22);
        3:       drive(1'b1, 2, 5'd23);
        4:       drive(1'b1, 3, 5'd24);
        9:       drive(1'b1, 4, 5'd25);
        default: in_valid = 1'b0;
      endcase
      #1;
      exp_ov = (c == 3 || c == 4 || c == 12);
      chk("t5_ov", 32'(out_valid), 32'(exp_ov));
      if (c == 3 || c == 4) chk("t5_tagA", 32'(out_tag), 32'd21);
      if (c == 4) chk("t5_rdy_fl", 32'(in_ready), 32'd0);
      if (c == 5) begin
        chk("t5_busy", 32'(busy),     32'd0);
        chk("t5_rdy",  32'(in_ready), 32'd1);
      end
      if (c == 12) begin
        chk("t5_data", out_data,     32'h40A00000);
        chk("t5_tag",  32'(out_tag), 32'd25);
      end
    end

    // asynchronous reset with three ops in flight
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b1, (c == 2) ? 0 : c + 5, 5'(26 + c));
    end
    tick(); in_valid = 1'b0; #1;
    chk("t6_ov_pre", 32'(out_valid), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("t6_ov",   32'(out_valid), 32'd0);
    chk("t6_data", out_data,       32'd0);
    chk("t6_tag",  32'(out_tag),   32'd0);
    chk("t6_dx1",  div_x1,         32'd0);
    chk("t6_busy", 32'(busy),      32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    chk("t6_rdy", 32'(in_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      chk("t6_quiet", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
